// File: rtl/alu_pkg.sv
// Shared opcode encodings and default datapath width for the execute-stage ALU.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_NEG = 3'd7;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA, also returning the last bit shifted out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]         data_i,
  input  logic [$clog2(WIDTH)-1:0] shamt_i,
  input  logic                     left_i,
  input  logic                     arith_i,
  output logic [WIDTH-1:0]         result_o,
  output logic                     shout_o
);

  // One guard bit beyond the data on the exit side captures the shift-out;
  // with a zero shift amount the guard stays 0, so no special case is needed.
  logic [WIDTH:0]   left_ext_s;
  logic [WIDTH+1:0] right_ext_s;
  logic             fill_s;

  // Compute both shift directions, then select the requested one.
  always_comb begin
    fill_s      = arith_i & data_i[WIDTH-1];
    left_ext_s  = {1'b0, data_i} << shamt_i;
    right_ext_s = $unsigned($signed({fill_s, data_i, 1'b0}) >>> shamt_i);
    if (left_i) begin
      result_o = left_ext_s[WIDTH-1:0];
      shout_o  = left_ext_s[WIDTH];
    end else begin
      result_o = right_ext_s[WIDTH:1];
      shout_o  = right_ext_s[0];
    end
  end

endmodule

// File: rtl/alu_core.sv
// 32-bit execute-stage ALU: combinational datapath followed by one register stage
// holding the result and the zero/carry/overflow/sign flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       alu_control,
  output logic [WIDTH-1:0] out,
  output logic             zflag,
  output logic             carryflag,
  output logic             overflowflag,
  output logic             signflag
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] add_a_s;
  logic [WIDTH-1:0] add_b_s;
  logic             add_cin_s;
  logic [WIDTH:0]   sum_s;
  logic             arith_ovf_s;
  logic [WIDTH-1:0] shift_res_s;
  logic             shift_out_s;
  logic [WIDTH-1:0] result_s;
  logic             carry_s;
  logic             ovf_s;

  logic [WIDTH-1:0] out_d, out_q;
  logic             zflag_d, zflag_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;
  logic             sign_d, sign_q;

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .data_i   (in1),
    .shamt_i  (in2[SHW-1:0]),
    .left_i   (alu_control == OP_SLL),
    .arith_i  (alu_control == OP_SRA),
    .result_o (shift_res_s),
    .shout_o  (shift_out_s)
  );

  // Share one adder: SUB is in1 + ~in2 + 1, NEG is 0 + ~in2 + 1.
  always_comb begin
    add_a_s   = in1;
    add_b_s   = in2;
    add_cin_s = 1'b0;
    case (alu_control)
      OP_SUB: begin
        add_b_s   = ~in2;
        add_cin_s = 1'b1;
      end
      OP_NEG: begin
        add_a_s   = {WIDTH{1'b0}};
        add_b_s   = ~in2;
        add_cin_s = 1'b1;
      end
      default: begin
        add_cin_s = 1'b0;
      end
    endcase
    sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{WIDTH{1'b0}}, add_cin_s};
    // Overflow on the adder's actual operands covers ADD, SUB and NEG alike.
    arith_ovf_s = (add_a_s[WIDTH-1] == add_b_s[WIDTH-1]) &&
                  (sum_s[WIDTH-1] != add_a_s[WIDTH-1]);
  end

  // Select the result and the carry/overflow flags for the current opcode.
  always_comb begin
    result_s = {WIDTH{1'b0}};
    carry_s  = 1'b0;
    ovf_s    = 1'b0;
    case (alu_control)
      OP_ADD, OP_SUB, OP_NEG: begin
        result_s = sum_s[WIDTH-1:0];
        carry_s  = sum_s[WIDTH];
        ovf_s    = arith_ovf_s;
      end
      OP_AND: result_s = in1 & in2;
      OP_XOR: result_s = in1 ^ in2;
      OP_SLL, OP_SRL, OP_SRA: begin
        result_s = shift_res_s;
        carry_s  = shift_out_s;
      end
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state values for the output register stage.
  always_comb begin
    out_d   = result_s;
    zflag_d = (result_s == {WIDTH{1'b0}});
    carry_d = carry_s;
    ovf_d   = ovf_s;
    sign_d  = result_s[WIDTH-1];
  end

  // Output register stage; cleared asynchronously while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= {WIDTH{1'b0}};
      zflag_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      zflag_q <= zflag_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      sign_q  <= sign_d;
    end
  end

  assign out          = out_q;
  assign zflag        = zflag_q;
  assign carryflag    = carry_q;
  assign overflowflag = ovf_q;
  assign signflag     = sign_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed corner cases, a random back-to-back
// burst against an independent reference model, and asynchronous reset checks.
module tb_alu_core;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] out;
    logic         z;
    logic         c;
    logic         v;
    logic         s;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [2:0]   alu_control;
  logic [W-1:0] out;
  logic         zflag, carryflag, overflowflag, signflag;

  res_t  exp_q[$];
  string tag_q[$];
  int    test_cnt = 0;
  int    fail_cnt = 0;
  res_t  last_exp;

  alu_core #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in1          (in1),
    .in2          (in2),
    .alu_control  (alu_control),
    .out          (out),
    .zflag        (zflag),
    .carryflag    (carryflag),
    .overflowflag (overflowflag),
    .signflag     (signflag)
  );

  always #5 clk = ~clk;

  function automatic res_t mk(logic [W-1:0] o, logic z, logic c, logic v, logic s);
    res_t r;
    r.out = o; r.z = z; r.c = c; r.v = v; r.s = s;
    return r;
  endfunction

  function automatic res_t observed();
    return mk(out, zflag, carryflag, overflowflag, signflag);
  endfunction

  // Reference model written from the opcode definitions using wide integer math.
  function automatic res_t ref_model(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    res_t   r;
    longint sa, sb, sr;
    int     sh;
    r  = mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    case (op)
      OP_ADD: begin
        r.out = a + b;
        r.c   = ({32'h0, a} + {32'h0, b}) > 64'h0000_0000_FFFF_FFFF;
        sr    = sa + sb;
        r.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      OP_SUB: begin
        r.out = a - b;
        r.c   = (a >= b);
        sr    = sa - sb;
        r.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      OP_AND: r.out = a & b;
      OP_XOR: r.out = a ^ b;
      OP_SLL: begin
        r.out = a << sh;
        r.c   = (sh == 0) ? 1'b0 : a[32-sh];
      end
      OP_SRL: begin
        r.out = a >> sh;
        r.c   = (sh == 0) ? 1'b0 : a[sh-1];
      end
      OP_SRA: begin
        r.out = $unsigned($signed(a) >>> sh);
        r.c   = (sh == 0) ? 1'b0 : a[sh-1];
      end
      default: begin
        r.out = 32'h0 - b;
        r.c   = (b == 32'h0);
        r.v   = (b == 32'h8000_0000);
      end
    endcase
    r.z = (r.out == 32'h0);
    r.s = r.out[31];
    return r;
  endfunction

  task automatic check(string tag, res_t got, res_t exp);
    test_cnt++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("FAIL %s: got out=%h z=%b c=%b v=%b s=%b, expected out=%h z=%b c=%b v=%b s=%b",
             tag, got.out, got.z, got.c, got.v, got.s, exp.out, exp.z, exp.c, exp.v, exp.s);
    end
  endtask

  task automatic drive(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op, string tag, res_t exp);
    in1         = a;
    in2         = b;
    alu_control = op;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // Advance one edge and compare the oldest scoreboard entry with the outputs.
  task automatic step();
    res_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      test_cnt++;
      fail_cnt++;
      $error("FAIL scoreboard: got no pending entry, expected one");
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check(tag_q.pop_front(), observed(), e);
    end
  endtask

  task automatic run(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op, string tag, res_t exp);
    drive(a, b, op, tag, exp);
    step();
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    res_t         zero_r;
    zero_r = mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted before any clock edge, with arbitrary inputs.
    rst_n       = 1'b0;
    in1         = 32'hDEAD_BEEF;
    in2         = 32'h1234_5678;
    alu_control = OP_ADD;
    #2;
    check("reset_async", observed(), zero_r);
    #6;
    check("reset_held", observed(), zero_r);
    rst_n = 1'b1;

    // Directed corners (out, z, c, v, s).
    run(32'd43,         32'd5,          OP_ADD, "add_43_5",     mk(32'd48,         1'b0, 1'b0, 1'b0, 1'b0));
    run(32'd4,          32'd2,          OP_SLL, "sll_4_2",      mk(32'd16,         1'b0, 1'b0, 1'b0, 1'b0));
    run(32'h8000_0001,  32'd1,          OP_SLL, "sll_shiftout", mk(32'h0000_0002,  1'b0, 1'b1, 1'b0, 1'b0));
    run(32'h7FFF_FFFF,  32'd1,          OP_ADD, "add_ovf",      mk(32'h8000_0000,  1'b0, 1'b0, 1'b1, 1'b1));
    run(32'hFFFF_FFFF,  32'd1,          OP_ADD, "add_carry",    mk(32'h0000_0000,  1'b1, 1'b1, 1'b0, 1'b0));
    run(32'd5,          32'd5,          OP_SUB, "sub_5_5",      mk(32'h0000_0000,  1'b1, 1'b1, 1'b0, 1'b0));
    run(32'd3,          32'd5,          OP_SUB, "sub_3_5",      mk(32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0, 1'b1));
    run(32'h8000_0000,  32'd1,          OP_SUB, "sub_ovf",      mk(32'h7FFF_FFFF,  1'b0, 1'b1, 1'b1, 1'b0));
    run(32'h8000_0000,  32'd4,          OP_SRA, "sra_4",        mk(32'hF800_0000,  1'b0, 1'b0, 1'b0, 1'b1));
    run(32'h8000_0000,  32'd4,          OP_SRL, "srl_4",        mk(32'h0800_0000,  1'b0, 1'b0, 1'b0, 1'b0));
    run(32'h0000_0003,  32'hFFFF_FFE1,  OP_SRL, "srl_hi_ign",   mk(32'h0000_0001,  1'b0, 1'b1, 1'b0, 1'b0));
    run(32'hC000_0000,  32'd31,         OP_SRA, "sra_31",       mk(32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0, 1'b1));
    run(32'h1234_5678,  32'h0000_0020,  OP_SLL, "sll_zero",     mk(32'h1234_5678,  1'b0, 1'b0, 1'b0, 1'b0));
    run(32'h5555_5555,  32'd1,          OP_NEG, "neg_1",        mk(32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, 1'b1));
    run(32'h0000_0000,  32'h8000_0000,  OP_NEG, "neg_min",      mk(32'h8000_0000,  1'b0, 1'b0, 1'b1, 1'b1));
    run(32'hFFFF_FFFF,  32'h0000_0000,  OP_NEG, "neg_0",        mk(32'h0000_0000,  1'b1, 1'b1, 1'b0, 1'b0));
    run(32'hF0F0_F0F0,  32'h0FF0_0FF0,  OP_AND, "and",          mk(32'h00F0_00F0,  1'b0, 1'b0, 1'b0, 1'b0));
    run(32'hA5A5_A5A5,  32'hA5A5_A5A5,  OP_XOR, "xor_zero",     mk(32'h0000_0000,  1'b1, 1'b0, 1'b0, 1'b0));

    // Back-to-back random operations: the outputs must hold the previous result
    // until the edge, then show the new one.
    for (int i = 0; i < 24; i++) begin
      ra  = $urandom();
      rb  = $urandom();
      rop = 3'($urandom_range(7, 0));
      drive(ra, rb, rop, $sformatf("b2b_%0d_op%0d", i, rop), ref_model(ra, rb, rop));
      #1;
      check($sformatf("b2b_hold_%0d", i), observed(), last_exp);
      step();
    end

    // Mid-run reset pulse between edges.
    run(32'h1111_1111, 32'h2222_2222, OP_ADD, "pre_reset", mk(32'h3333_3333, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    check("midrun_reset", observed(), zero_r);
    in1         = 32'h7FFF_FFFF;
    in2         = 32'h7FFF_FFFF;
    alu_control = OP_ADD;
    rst_n       = 1'b1;
    #1;
    check("after_release", observed(), zero_r);
    drive(32'h7FFF_FFFF, 32'h7FFF_FFFF, OP_ADD, "post_reset", mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1));
    step();

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
